// File: rtl/modu2_stim_gen_if.sv
// modu2_stim_gen_if
// Purpose: carries one operand vector for the modu2 datapath from the stimulus
//          generator to its consumer, with a valid/ready handshake so the
//          consumer can apply backpressure.
// Signals:
//   out_valid  master->slave  A/B/C/D/vec_idx hold a valid vector
//   out_ready  slave->master  consumer accepts the current vector
//   A, B       master->slave  1-bit operands
//   C, D       master->slave  10-bit operands
//   vec_idx    master->slave  0-based index of the presented vector
interface modu2_stim_gen_if #(
    parameter int CNT_W = 20
);
    logic             out_valid;
    logic             out_ready;
    logic             A;
    logic             B;
    logic [9:0]       C;
    logic [9:0]       D;
    logic [CNT_W-1:0] vec_idx;

    modport master (
        output out_valid, A, B, C, D, vec_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid, A, B, C, D, vec_idx,
        output out_ready
    );
endinterface

// File: rtl/modu2_stim_gen.sv
// modu2_stim_gen
// Purpose: seedable, reproducible source of pseudo-random operand vectors for
//          the modu2 datapath. A 32-bit Galois LFSR supplies the operand bits;
//          a run of num_vec vectors is presented over a valid/ready handshake.
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run of num_vec vectors (idle only)
//   num_vec    in   run length, sampled when start is accepted
//   seed_load  in   load the LFSR from seed_in (idle only, wins over start)
//   seed_in    in   new LFSR seed; zero selects SEED instead
//   vec        if   master side of the vector handshake (A, B, C, D, vec_idx)
//   busy       out  high while a run is in progress
//   done       out  one-cycle pulse when a run finishes
module modu2_stim_gen #(
    parameter logic [31:0] SEED  = 32'h0000_0001,
    parameter int          CNT_W = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_vec,
    input  logic                  seed_load,
    input  logic [31:0]           seed_in,
    modu2_stim_gen_if.master      vec,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [31:0]      lfsr;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] idx;
    logic             valid_r;
    logic             a_r;
    logic             b_r;
    logic [9:0]       c_r;
    logic [9:0]       d_r;
    logic             xfer;

    // Galois step with taps 32'h8020_0003; a non-zero state never reaches zero.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    assign xfer          = valid_r & vec.out_ready;
    assign vec.out_valid = valid_r;
    assign vec.A         = a_r;
    assign vec.B         = b_r;
    assign vec.C         = c_r;
    assign vec.D         = d_r;
    assign vec.vec_idx   = idx;

    // Run control. Loading a vector captures the operand fields from the
    // current LFSR value and then advances the LFSR, so the first vector of a
    // freshly seeded run is the seed itself. Under backpressure nothing
    // presented changes. On the last transfer the outputs keep the last
    // vector and only valid drops. done is registered on entry to DONE so it
    // is high for exactly the one cycle spent there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lfsr    <= SEED;
            num_lat <= '0;
            idx     <= '0;
            valid_r <= 1'b0;
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            c_r     <= '0;
            d_r     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (seed_load) begin
                        lfsr <= (seed_in == 32'h0) ? SEED : seed_in;
                    end else if (start) begin
                        if (num_vec != '0) begin
                            num_lat <= num_vec;
                            idx     <= '0;
                            a_r     <= lfsr[0];
                            b_r     <= lfsr[1];
                            c_r     <= lfsr[11:2];
                            d_r     <= lfsr[21:12];
                            lfsr    <= lfsr_step(lfsr);
                            valid_r <= 1'b1;
                            busy    <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (idx == num_lat - ONE) begin
                            valid_r <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            a_r  <= lfsr[0];
                            b_r  <= lfsr[1];
                            c_r  <= lfsr[11:2];
                            d_r  <= lfsr[21:12];
                            lfsr <= lfsr_step(lfsr);
                            idx  <= idx + ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modu2_stim_gen.sv
// tb_modu2_stim_gen
// Self-checking bench for modu2_stim_gen: directed vector tables for the
// known seed-1 sequence, hand-written sequences for backpressure, empty runs,
// zero seed, ignored start and mid-run reset, and a long random-backpressure
// run checked against an LFSR reference model.
module tb_modu2_stim_gen;

    localparam int CNT_W       = 20;
    localparam int RAND_N      = 2000;
    localparam int RAND_BUDGET = 20000;

    typedef struct {
        logic             a;
        logic             b;
        logic [9:0]       c;
        logic [9:0]       d;
        logic [CNT_W-1:0] idx;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             seed_load;
    logic [31:0]      seed_in;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    vec_t tbl[3];

    modu2_stim_gen_if #(.CNT_W(CNT_W)) vec ();

    modu2_stim_gen #(.SEED(32'h0000_0001), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_vec   (num_vec),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .vec       (vec),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference LFSR step: shift right, xor taps when the dropped bit was 1.
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input vec_t e);
        check_val({name, " valid"}, 32'(vec.out_valid), 32'h1);
        check_val({name, " A"}, 32'(vec.A), 32'(e.a));
        check_val({name, " B"}, 32'(vec.B), 32'(e.b));
        check_val({name, " C"}, 32'(vec.C), 32'(e.c));
        check_val({name, " D"}, 32'(vec.D), 32'(e.d));
        check_val({name, " idx"}, 32'(vec.vec_idx), 32'(e.idx));
    endtask

    task automatic check_idle_after_done(input string name);
        check_val({name, " done"}, 32'(done), 32'h1);
        check_val({name, " valid low"}, 32'(vec.out_valid), 32'h0);
        check_val({name, " busy low"}, 32'(busy), 32'h0);
        tick();
        check_val({name, " done drop"}, 32'(done), 32'h0);
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic start_run(input int n);
        start   = 1'b1;
        num_vec = CNT_W'(n);
        tick();
        start   = 1'b0;
    endtask

    // Seed 1, three vectors, consumer always ready.
    task automatic run_case1(input string tag);
        load_seed(32'h1);
        vec.out_ready = 1'b1;
        start_run(3);
        for (int i = 0; i < 3; i++) begin
            check_vec($sformatf("%s vec%0d", tag, i), tbl[i]);
            check_val($sformatf("%s busy%0d", tag, i), 32'(busy), 32'h1);
            check_val($sformatf("%s nodone%0d", tag, i), 32'(done), 32'h0);
            tick();
        end
        check_idle_after_done(tag);
    endtask

    initial begin
        logic [31:0] exp_state;
        logic [31:0] rseed;
        int          xfers;
        int          cycles;
        logic        rdy;
        vec_t        e;

        tbl[0] = '{a: 1'b1, b: 1'b0, c: 10'h000, d: 10'h000, idx: 20'd0};
        tbl[1] = '{a: 1'b1, b: 1'b1, c: 10'h000, d: 10'h200, idx: 20'd1};
        tbl[2] = '{a: 1'b0, b: 1'b1, c: 10'h000, d: 10'h300, idx: 20'd2};

        rst_n         = 1'b0;
        start         = 1'b0;
        num_vec       = '0;
        seed_load     = 1'b0;
        seed_in       = '0;
        vec.out_ready = 1'b0;

        // Reset state.
        #12;
        check_val("reset valid", 32'(vec.out_valid), 32'h0);
        check_val("reset ABCD", {10'h0, vec.D, vec.C, vec.B, vec.A}, 32'h0);
        check_val("reset idx", 32'(vec.vec_idx), 32'h0);
        check_val("reset busy", 32'(busy), 32'h0);
        check_val("reset done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] case 1: seed 1, three vectors");
        run_case1("case1");

        $display("[TB] case 2: backpressure on vector 1");
        load_seed(32'h1);
        vec.out_ready = 1'b1;
        start_run(3);
        check_vec("case2 vec0", tbl[0]);
        tick();
        check_vec("case2 vec1", tbl[1]);
        vec.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_vec($sformatf("case2 hold%0d", i), tbl[1]);
            check_val($sformatf("case2 hold busy%0d", i), 32'(busy), 32'h1);
        end
        vec.out_ready = 1'b1;
        tick();
        check_vec("case2 vec2", tbl[2]);
        tick();
        check_idle_after_done("case2");

        $display("[TB] case 3: empty run");
        start_run(0);
        check_idle_after_done("case3");
        check_val("case3 no valid", 32'(vec.out_valid), 32'h0);

        $display("[TB] case 4: zero seed and start ignored in run");
        load_seed(32'h0);
        vec.out_ready = 1'b0;
        start_run(1);
        check_vec("case4 vec0", tbl[0]);
        start   = 1'b1;
        num_vec = CNT_W'(5);
        tick();
        start = 1'b0;
        check_vec("case4 vec0 held", tbl[0]);
        vec.out_ready = 1'b1;
        tick();
        check_idle_after_done("case4");
        tick();
        check_val("case4 single vector", 32'(vec.out_valid), 32'h0);
        check_val("case4 no second done", 32'(done), 32'h0);

        $display("[TB] case 5: reset mid-run");
        load_seed(32'h1);
        vec.out_ready = 1'b1;
        start_run(10);
        repeat (5) tick();
        check_val("case5 idx before reset", 32'(vec.vec_idx), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("case5 async valid", 32'(vec.out_valid), 32'h0);
        check_val("case5 async ABCD", {10'h0, vec.D, vec.C, vec.B, vec.A}, 32'h0);
        check_val("case5 async idx", 32'(vec.vec_idx), 32'h0);
        check_val("case5 async busy", 32'(busy), 32'h0);
        tick();
        check_val("case5 no done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick();
        check_val("case5 idle done", 32'(done), 32'h0);
        run_case1("case5 rerun");

        $display("[TB] case 6: random backpressure run of %0d vectors", RAND_N);
        rseed = $urandom() | 32'h1;
        load_seed(rseed);
        vec.out_ready = 1'b0;
        start_run(RAND_N);
        exp_state = rseed;
        xfers     = 0;
        cycles    = 0;
        while (xfers < RAND_N && cycles < RAND_BUDGET) begin
            e.a   = exp_state[0];
            e.b   = exp_state[1];
            e.c   = exp_state[11:2];
            e.d   = exp_state[21:12];
            e.idx = CNT_W'(xfers);
            check_vec("rand vec", e);
            check_val("rand no done", 32'(done), 32'h0);
            rdy = 1'($urandom_range(0, 1));
            vec.out_ready = rdy;
            tick();
            cycles++;
            if (rdy) begin
                xfers++;
                if (xfers < RAND_N) exp_state = ref_step(exp_state);
            end
        end
        check_val("rand transfers", 32'(xfers), 32'(RAND_N));
        check_val("rand final idx", 32'(vec.vec_idx), 32'(RAND_N - 1));
        check_val("rand last D", 32'(vec.D), 32'(exp_state[21:12]));
        check_idle_after_done("rand");

        // The LFSR continues across runs: next vector is one step past the last.
        exp_state     = ref_step(exp_state);
        vec.out_ready = 1'b1;
        start_run(1);
        check_val("rand continue ABCD", {10'h0, vec.D, vec.C, vec.B, vec.A}, {10'h0, exp_state[21:0]});
        check_val("rand continue idx", 32'(vec.vec_idx), 32'h0);
        tick();
        check_idle_after_done("rand continue");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
